// File: rtl/core_dbg_ctrl.sv
// Debug run-control block: memory-mapped halt / resume / single-step handshake with a core.
// Optional wait-timeout abort is compiled in with `define CORE_DBG_TIMEOUT_EN.
module core_dbg_ctrl #(
  parameter int MEMI_NR_SLAVES   = 1,
  parameter int MEMI_ADDR_WIDTH  = 5,
  parameter int MEMI_WDATA_WIDTH = 32,
  parameter int SLAVE_ID         = 0
) (
  input  logic                        memi_clk,
  input  logic                        memi_rst_n,
  input  logic [MEMI_ADDR_WIDTH-1:0]  memi_addr,
  input  logic [MEMI_NR_SLAVES-1:0]   memi_sel,
  input  logic                        memi_wr_rd,
  input  logic [MEMI_WDATA_WIDTH-1:0] memi_wdata,
  output logic [MEMI_WDATA_WIDTH-1:0] memi_rdata,
  output logic                        memi_rvalid,
  output logic                        dbg_halt_req,
  output logic                        dbg_resume_req,
  output logic                        dbg_step,
  input  logic                        core_halted
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALTING   = 3'd1,
    ST_RESUMING  = 3'd2,
    ST_STEP_RUN  = 3'd3,
    ST_STEP_HALT = 3'd4
  } state_e;

  localparam logic [MEMI_ADDR_WIDTH-1:0] ADDR_CTRL     = MEMI_ADDR_WIDTH'(32'd0);
  localparam logic [MEMI_ADDR_WIDTH-1:0] ADDR_STATUS   = MEMI_ADDR_WIDTH'(32'd1);
  localparam logic [MEMI_ADDR_WIDTH-1:0] ADDR_TIMEOUT  = MEMI_ADDR_WIDTH'(32'd2);
  localparam logic [MEMI_ADDR_WIDTH-1:0] ADDR_STEP_CNT = MEMI_ADDR_WIDTH'(32'd3);

  state_e                      state_q, state_d;
  logic                        halt_req_q, halt_req_d;
  logic                        resume_req_q, resume_req_d;
  logic                        step_q, step_d;
  logic                        drop_sticky_q, drop_sticky_d;
  logic [15:0]                 step_cnt_q, step_cnt_d;
  logic [MEMI_WDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d;

  logic        acc_s, wr_s, rd_s, ctrl_wr_s;
  logic        cmd_halt_s, cmd_resume_s, cmd_step_s, cmd_any_s, clr_sticky_s;
  logic        busy_s, drop_s, timeout_hit_s, step_done_s;
  logic        wait_expired_s, to_sticky_s;
  logic [15:0] timeout_s;
  logic        unused_s;

  assign acc_s        = memi_sel[SLAVE_ID];
  assign wr_s         = acc_s & memi_wr_rd;
  assign rd_s         = acc_s & ~memi_wr_rd;
  assign ctrl_wr_s    = wr_s & (memi_addr == ADDR_CTRL);
  assign cmd_halt_s   = ctrl_wr_s & memi_wdata[0];
  assign cmd_resume_s = ctrl_wr_s & memi_wdata[1];
  assign cmd_step_s   = ctrl_wr_s & memi_wdata[2];
  assign clr_sticky_s = ctrl_wr_s & memi_wdata[3];
  assign cmd_any_s    = cmd_halt_s | cmd_resume_s | cmd_step_s;
  assign busy_s       = (state_q != ST_IDLE);
  assign unused_s     = &{1'b0, memi_sel, memi_wdata, timeout_hit_s};

`ifdef CORE_DBG_TIMEOUT_EN
  logic [15:0] timeout_q, timeout_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] wait_cnt_inc_s;
  logic        to_sticky_q, to_sticky_d;

  // The compare uses the count including the current cycle, so TIMEOUT=N allows N wait cycles
  assign wait_cnt_inc_s = wait_cnt_q + 16'd1;
  assign wait_expired_s = (timeout_q != 16'd0) && (wait_cnt_inc_s == timeout_q);
  assign timeout_s      = timeout_q;
  assign to_sticky_s    = to_sticky_q;

  // Timeout register, wait counter and timeout sticky next-state
  always_comb begin
    if (wr_s && (memi_addr == ADDR_TIMEOUT)) begin
      timeout_d = memi_wdata[15:0];
    end else begin
      timeout_d = timeout_q;
    end
    if (state_d != state_q) begin
      wait_cnt_d = 16'd0;
    end else if (state_q != ST_IDLE) begin
      wait_cnt_d = wait_cnt_inc_s;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    if (clr_sticky_s) begin
      to_sticky_d = timeout_hit_s;
    end else begin
      to_sticky_d = to_sticky_q | timeout_hit_s;
    end
  end

  // Timeout-related registers
  always_ff @(posedge memi_clk or negedge memi_rst_n) begin
    if (!memi_rst_n) begin
      timeout_q   <= 16'h0100;
      wait_cnt_q  <= 16'd0;
      to_sticky_q <= 1'b0;
    end else begin
      timeout_q   <= timeout_d;
      wait_cnt_q  <= wait_cnt_d;
      to_sticky_q <= to_sticky_d;
    end
  end
`else
  assign wait_expired_s = 1'b0;
  assign timeout_s      = 16'd0;
  assign to_sticky_s    = 1'b0;
`endif

  // Next-state logic: command decode, handshake completion and abort
  always_comb begin
    state_d       = state_q;
    drop_s        = busy_s & cmd_any_s;
    timeout_hit_s = 1'b0;
    step_done_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_halt_s) begin
          state_d = ST_HALTING;
        end else if (cmd_resume_s) begin
          state_d = ST_RESUMING;
        end else if (cmd_step_s) begin
          if (core_halted) begin
            state_d = ST_STEP_RUN;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTING: begin
        if (core_halted) begin
          state_d = ST_IDLE;
        end else if (wait_expired_s) begin
          state_d       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = ST_HALTING;
        end
      end
      ST_RESUMING: begin
        if (!core_halted) begin
          state_d = ST_IDLE;
        end else if (wait_expired_s) begin
          state_d       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = ST_RESUMING;
        end
      end
      ST_STEP_RUN: begin
        if (!core_halted) begin
          state_d = ST_STEP_HALT;
        end else if (wait_expired_s) begin
          state_d       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = ST_STEP_RUN;
        end
      end
      ST_STEP_HALT: begin
        if (core_halted) begin
          state_d     = ST_IDLE;
          step_done_s = 1'b1;
        end else if (wait_expired_s) begin
          state_d       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = ST_STEP_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request decode of the next state, so the request flops always mirror state_q
  always_comb begin
    halt_req_d   = 1'b0;
    resume_req_d = 1'b0;
    step_d       = 1'b0;
    case (state_d)
      ST_HALTING:  halt_req_d = 1'b1;
      ST_RESUMING: resume_req_d = 1'b1;
      ST_STEP_RUN: begin
        resume_req_d = 1'b1;
        step_d       = 1'b1;
      end
      default:     halt_req_d = 1'b0;
    endcase
  end

  // Drop sticky, step counter and registered read path
  always_comb begin
    if (clr_sticky_s) begin
      drop_sticky_d = drop_s;
    end else begin
      drop_sticky_d = drop_sticky_q | drop_s;
    end
    if (step_done_s) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end else begin
      step_cnt_d = step_cnt_q;
    end
    rdata_d  = {MEMI_WDATA_WIDTH{1'b0}};
    rvalid_d = 1'b0;
    if (rd_s) begin
      rvalid_d = 1'b1;
      case (memi_addr)
        ADDR_STATUS:   rdata_d[6:0]  = {state_q, drop_sticky_q, to_sticky_s, busy_s, core_halted};
        ADDR_TIMEOUT:  rdata_d[15:0] = timeout_s;
        ADDR_STEP_CNT: rdata_d[15:0] = step_cnt_q;
        default:       rdata_d       = {MEMI_WDATA_WIDTH{1'b0}};
      endcase
    end else begin
      rvalid_d = 1'b0;
    end
  end

  // State register and all output registers
  always_ff @(posedge memi_clk or negedge memi_rst_n) begin
    if (!memi_rst_n) begin
      state_q       <= ST_IDLE;
      halt_req_q    <= 1'b0;
      resume_req_q  <= 1'b0;
      step_q        <= 1'b0;
      drop_sticky_q <= 1'b0;
      step_cnt_q    <= 16'd0;
      rdata_q       <= {MEMI_WDATA_WIDTH{1'b0}};
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_req_q    <= halt_req_d;
      resume_req_q  <= resume_req_d;
      step_q        <= step_d;
      drop_sticky_q <= drop_sticky_d;
      step_cnt_q    <= step_cnt_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign memi_rdata     = rdata_q;
  assign memi_rvalid    = rvalid_q;
  assign dbg_halt_req   = halt_req_q;
  assign dbg_resume_req = resume_req_q;
  assign dbg_step       = step_q;

endmodule
